// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a small transmit FIFO.
// The line outputs are registered one cycle behind the FSM state so that txd, busy and done stay aligned.
module uart_tx_cfg #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 5208,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state_q, state_d;
    logic [BW-1:0]          baud_q, baud_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   txd_q, txd_d;
    logic                   busy_q, busy_d;
    logic                   end_q, end_d;
    logic                   done_q, done_d;
    logic                   ready_q, ready_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];

    logic wr_en;
    logic pop;
    logic bit_end;
    logic fifo_empty;

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        end_d      = 1'b0;
        pop        = 1'b0;
        wr_en      = tx_valid && ready_q;
        bit_end    = (baud_q == BAUD_LAST);
        fifo_empty = (count_q == '0);

        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + BW'(1);
        end

        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        end_d = 1'b1;
                        bit_d = '0;
                        // Popping here keeps back-to-back frames gapless.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            shift_d  = mem[rd_ptr_q];
            par_d    = (^mem[rd_ptr_q]) ^ (PARITY_ODD != 0);
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(wr_en) - CW'(pop);
        ready_d = (count_d != FULL_COUNT);

        case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[0];
            PARITY:  txd_d = par_q;
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_q != IDLE);
        done_d = end_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            end_q    <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            end_q    <= end_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= tx_data;
        end
    end

    assign tx_ready   = ready_q;
    assign txd        = txd_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboarded bench for uart_tx_cfg: one 8N1 instance with a line monitor
// plus parity and two-stop-bit instances checked frame by frame.
module tb_uart_tx_cfg;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] data0, data1, data2;
    logic [6:0] data3;
    logic       valid0, valid1, valid2, valid3;
    logic       ready0, ready1, ready2, ready3;
    logic       txd0, txd1, txd2, txd3;
    logic       busy0, busy1, busy2, busy3;
    logic       done0, done1, done2, done3;
    logic [2:0] cnt0, cnt1, cnt2, cnt3;

    logic [3:0] txd_all, done_all, busy_all, ready_all;
    assign txd_all   = {txd3, txd2, txd1, txd0};
    assign done_all  = {done3, done2, done1, done0};
    assign busy_all  = {busy3, busy2, busy1, busy0};
    assign ready_all = {ready3, ready2, ready1, ready0};

    uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .reset(reset), .tx_data(data0), .tx_valid(valid0), .tx_ready(ready0),
        .txd(txd0), .busy(busy0), .done(done0), .fifo_count(cnt0));
    uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .reset(reset), .tx_data(data1), .tx_valid(valid1), .tx_ready(ready1),
        .txd(txd1), .busy(busy1), .done(done1), .fifo_count(cnt1));
    uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .reset(reset), .tx_data(data2), .tx_valid(valid2), .tx_ready(ready2),
        .txd(txd2), .busy(busy2), .done(done2), .fifo_count(cnt2));
    uart_tx_cfg #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .reset(reset), .tx_data(data3), .tx_valid(valid3), .tx_ready(ready3),
        .txd(txd3), .busy(busy3), .done(done3), .fifo_count(cnt3));

    int total = 0;
    int bad = 0;
    logic [7:0]  exp_q0[$];
    logic [15:0] exp_frame_q[$];
    int done_count0 = 0;
    int run_len0 = 0;
    int last_run0 = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] build_frame(input logic [8:0] w, input int n_data,
                                                input bit par_en, input bit par_odd);
        logic [15:0] f;
        logic p;
        f = '1;
        f[0] = 1'b0;
        p = par_odd;
        for (int i = 0; i < n_data; i++) begin
            f[1+i] = w[i];
            p = p ^ w[i];
        end
        if (par_en) f[1+n_data] = p;
        return f;
    endfunction

    always @(negedge clk) if (done0 === 1'b1) done_count0++;

    // Decodes every 8N1 frame on txd0 and compares it against the scoreboard.
    logic line0 [40];
    always begin : monitor0
        logic [7:0] word;
        logic stable;
        bit aborted;
        int done_early;
        @(negedge clk);
        run_len0 = 0;
        while (reset === 1'b0 && txd0 === 1'b0) begin
            aborted = 0;
            done_early = 0;
            line0[0] = txd0;
            for (int c = 1; c < 40; c++) begin
                @(negedge clk);
                if (reset === 1'b1) begin
                    aborted = 1;
                    break;
                end
                line0[c] = txd0;
                if (done0 === 1'b1) done_early++;
            end
            if (aborted) break;
            @(negedge clk);
            checkOutput("done_at_40", 32'(done0), 32'd1);
            checkOutput("done_early", 32'(done_early), 32'd0);
            stable = 1'b1;
            for (int b = 0; b < 10; b++)
                for (int k = 1; k < CPB; k++)
                    if (line0[b*CPB+k] !== line0[b*CPB]) stable = 1'b0;
            for (int i = 0; i < 8; i++) word[i] = line0[(i+1)*CPB];
            checkOutput("frame0_stable", 32'(stable), 32'd1);
            checkOutput("frame0_stop", 32'(line0[36]), 32'd1);
            if (exp_q0.size() == 0) checkOutput("frame0_unexpected", 32'd1, 32'd0);
            else checkOutput("frame0_data", 32'(word), 32'(exp_q0.pop_front()));
            run_len0++;
            last_run0 = run_len0;
        end
    end

    task automatic applyStimulus(input logic [7:0] w, output logic acc);
        data0 = w;
        valid0 = 1'b1;
        acc = ready0;
        if (acc) exp_q0.push_back(w);
        @(negedge clk);
    endtask

    task automatic waitIdle0(input int limit);
        bit ok;
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (exp_q0.size() == 0 && busy0 === 1'b0 && txd0 === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) checkOutput("idle_timeout", 32'd1, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic applyCfgStimulus(input int idx, input logic [8:0] w, input int n_data,
                                    input bit par_en, input bit par_odd);
        checkOutput("cfg_ready", 32'(ready_all[idx]), 32'd1);
        exp_frame_q.push_back(build_frame(w, n_data, par_en, par_odd));
        case (idx)
            1: begin data1 = w[7:0]; valid1 = 1'b1; end
            2: begin data2 = w[7:0]; valid2 = 1'b1; end
            3: begin data3 = w[6:0]; valid3 = 1'b1; end
            default: ;
        endcase
        @(negedge clk);
        valid1 = 1'b0;
        valid2 = 1'b0;
        valid3 = 1'b0;
    endtask

    task automatic captureCfg(input int idx, input int n_bits, input int par_pos, input logic exp_par);
        logic [15:0] bits;
        logic [15:0] expf;
        int done_at;
        logic stable;
        bit found;
        bits = '1;
        done_at = -1;
        stable = 1'b1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (txd_all[idx] === 1'b0) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("cfg_start_seen", 32'(found), 32'd1);
        if (found) begin
            for (int c = 0; c <= n_bits*CPB + 1; c++) begin
                if (c < n_bits*CPB) begin
                    if (c % CPB == 0) bits[c/CPB] = txd_all[idx];
                    else if (txd_all[idx] !== bits[c/CPB]) stable = 1'b0;
                end
                if (c == 2) checkOutput("cfg_busy", 32'(busy_all[idx]), 32'd1);
                if (done_all[idx] === 1'b1 && done_at < 0) done_at = c;
                @(negedge clk);
            end
            expf = exp_frame_q.pop_front();
            checkOutput("cfg_frame", 32'(bits), 32'(expf));
            checkOutput("cfg_stable", 32'(stable), 32'd1);
            checkOutput("cfg_done_at", 32'(done_at), 32'(n_bits*CPB));
            if (par_pos > 0) checkOutput("cfg_parity", 32'(bits[par_pos]), 32'(exp_par));
        end
    endtask

    initial begin
        logic acc;
        int d;
        int lows;
        logic [7:0] burst [6];
        logic [7:0] w;
        burst = '{8'h11, 8'h22, 8'hF0, 8'h0F, 8'h81, 8'hEE};
        data0 = '0; data1 = '0; data2 = '0; data3 = '0;
        valid0 = 1'b0; valid1 = 1'b0; valid2 = 1'b0; valid3 = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_txd", 32'(txd_all), 32'hF);
        checkOutput("rst_busy", 32'(busy_all), 32'h0);
        checkOutput("rst_done", 32'(done_all), 32'h0);
        checkOutput("rst_count", 32'(cnt0), 32'd0);
        checkOutput("rst_ready", 32'(ready_all), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst", 32'(ready_all), 32'hF);

        // Single 0xA5 frame and the write-to-start latency.
        d = done_count0;
        applyStimulus(8'hA5, acc);
        valid0 = 1'b0;
        checkOutput("txd_e0", 32'(txd0), 32'd1);
        @(negedge clk);
        checkOutput("txd_e1", 32'(txd0), 32'd1);
        @(negedge clk);
        checkOutput("txd_e2", 32'(txd0), 32'd0);
        checkOutput("busy_frame", 32'(busy0), 32'd1);
        waitIdle0(200);
        checkOutput("done_cnt_a5", 32'(done_count0 - d), 32'd1);

        // Fill the FIFO, get refused when full, then write alongside a pop at count 3.
        d = done_count0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(burst[i], acc);
            checkOutput($sformatf("burst_acc%0d", i), 32'(acc), (i < 5) ? 32'd1 : 32'd0);
        end
        valid0 = 1'b0;
        checkOutput("count_full", 32'(cnt0), 32'd4);
        checkOutput("ready_full", 32'(ready0), 32'd0);
        repeat (75) @(negedge clk);
        checkOutput("count_pre_pop", 32'(cnt0), 32'd3);
        applyStimulus(8'h3C, acc);
        valid0 = 1'b0;
        checkOutput("acc_with_pop", 32'(acc), 32'd1);
        checkOutput("count_with_pop", 32'(cnt0), 32'd3);
        waitIdle0(400);
        checkOutput("burst_done_cnt", 32'(done_count0 - d), 32'd6);
        checkOutput("burst_contig", 32'(last_run0), 32'd6);

        // Reset in the middle of the third data bit with two words queued.
        d = done_count0;
        w = 8'h4D;
        applyStimulus(w, acc);
        applyStimulus(8'hC3, acc);
        applyStimulus(8'h96, acc);
        valid0 = 1'b0;
        checkOutput("rst_test_start", 32'(txd0), 32'd0);
        repeat (13) @(negedge clk);
        checkOutput("bit2_level", 32'(txd0), 32'(w[2]));
        checkOutput("count_two_queued", 32'(cnt0), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_txd", 32'(txd0), 32'd1);
        checkOutput("abort_count", 32'(cnt0), 32'd0);
        checkOutput("abort_busy", 32'(busy0), 32'd0);
        checkOutput("abort_done", 32'(done0), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q0.delete();
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd0 !== 1'b1) lows++;
        end
        checkOutput("no_frames_after_rst", 32'(lows), 32'd0);
        checkOutput("no_done_after_rst", 32'(done_count0 - d), 32'd0);
        checkOutput("count_after_rst", 32'(cnt0), 32'd0);
        checkOutput("ready_after_abort", 32'(ready0), 32'd1);

        // Even parity, odd parity, and 7 data bits with two stop bits.
        applyCfgStimulus(1, 9'h07, 8, 1'b1, 1'b0);
        captureCfg(1, 11, 9, 1'b1);
        checkOutput("cfg1_count", 32'(cnt1), 32'd0);
        applyCfgStimulus(2, 9'h07, 8, 1'b1, 1'b1);
        captureCfg(2, 11, 9, 1'b0);
        checkOutput("cfg2_count", 32'(cnt2), 32'd0);
        applyCfgStimulus(3, 9'h55, 7, 1'b0, 1'b0);
        captureCfg(3, 10, 0, 1'b0);
        checkOutput("cfg3_count", 32'(cnt3), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter DATA_BITS, default 8; data bits per frame; legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 5208; clk cycles per bit; legal range 2 and up.
REQ-003 Parameter PARITY_EN, default 0; 1 inserts a parity bit after the data bits.
REQ-004 Parameter PARITY_ODD, default 0; 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
REQ-005 Parameter STOP_BITS, default 1; stop bits per frame; legal values 1 or 2.
REQ-006 Parameter FIFO_DEPTH, default 4; transmit FIFO entries; power of 2, at least 2.
REQ-007 clk  in  1  sole clock; all logic is on the rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 tx_data  in  DATA_BITS  word to enqueue.
REQ-010 tx_valid  in  1  enqueue request.
REQ-011 tx_ready  out  1  FIFO not full; a write occurs only when tx_valid and tx_ready are both high in the same cycle.
REQ-012 txd  out  1  serial line; registered; high when idle.
REQ-013 busy  out  1  high while a frame is on the line.
REQ-014 done  out  1  one-cycle pulse at completion of each frame.
REQ-015 fifo_count  out  clog2(FIFO_DEPTH)+1  number of words queued, excluding the frame in flight.

Function
REQ-016 Frame order SHALL be: start (0), data bits LSB first, optional parity bit, then STOP_BITS stop bits (1).
REQ-017 Every bit SHALL last exactly CLKS_PER_BIT cycles; the baud counter restarts at 0 at each bit boundary; counter width is clog2(CLKS_PER_BIT).
REQ-018 Frame length SHALL be (1+DATA_BITS+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-019 Parity SHALL be the XOR of the data bits, inverted when PARITY_ODD=1.
REQ-020 FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE->START when FIFO is non-empty.
- START->DATA after 1 bit time.
- DATA->PARITY, or DATA->STOP when PARITY_EN=0, after DATA_BITS bit times.
- PARITY->STOP after 1 bit time.
- STOP->START when FIFO is non-empty, otherwise STOP->IDLE, after STOP_BITS bit times.
REQ-021 The FIFO head SHALL be popped into the shift register on each entry to START; txd SHALL go low on the cycle after the pop decision.
REQ-022 A write accepted into an empty FIFO while in IDLE SHALL drive txd low 2 cycles after the write edge.
REQ-023 Back-to-back frames SHALL have no idle cycles between the last stop bit and the next start bit.
REQ-024 done SHALL pulse for exactly 1 cycle, in the first cycle after the final stop bit's last cycle, including on back-to-back frames.
REQ-025 Simultaneous write and pop SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-026 With tx_valid high while full, the write SHALL be ignored and the FIFO contents left unchanged.
REQ-027 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; full when fifo_count = FIFO_DEPTH.
REQ-028 busy SHALL be high in every state except IDLE.

Reset
REQ-029 While reset is high: txd=1, busy=0, done=0, fifo_count=0, tx_ready=0; FSM in IDLE; baud and bit counters 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame; txd=1 on the next edge; queued data SHALL be discarded; no done pulse.
REQ-031 tx_ready SHALL be 1 from the first cycle after reset deasserts.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-032 8N1, write 0xA5 once -> txd low for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4; done pulses once, 40 cycles after txd first falls.
REQ-033 PARITY_EN=1: write 0x07 -> parity bit 1 with PARITY_ODD=0 and 0 with PARITY_ODD=1; frame is 44 cycles.
REQ-034 FIFO_DEPTH=4: write 5 words on consecutive cycles -> all accepted (1 in flight, 4 queued); a 6th write is refused with tx_ready=0; 5 frames go out contiguously with 5 done pulses.
REQ-035 At fifo_count=3, write coinciding with a pop -> fifo_count stays 3; output order matches write order.
REQ-036 Reset during the 3rd data bit with 2 words queued -> txd=1 next cycle, fifo_count=0, busy=0, no done, no further frames.
REQ-037 DATA_BITS=7, STOP_BITS=2, PARITY_EN=0: write 0x55 -> frame of 10 bit times (40 cycles) with 2 stop bits high.
